// File: rtl/uart_rx_pkg.sv
// Shared types and baud-code helpers for the UART receive link manager.
// Optional statistics counters in the top level are built only when UART_RX_LINK_STATS_EN is defined.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_SETTLE = 3'd1,
        ST_HUNT   = 3'd2,
        ST_LOCKED = 3'd3,
        ST_STEP   = 3'd4
    } link_state_e;

    localparam logic [2:0] BC_9600   = 3'b000;
    localparam logic [2:0] BC_19200  = 3'b001;
    localparam logic [2:0] BC_38400  = 3'b010;
    localparam logic [2:0] BC_57600  = 3'b011;
    localparam logic [2:0] BC_115200 = 3'b100;
    localparam logic [2:0] BC_MAX    = 3'b100;

    // Codes above the fastest rate have no meaning and fall back to the slowest rate.
    function automatic logic [2:0] sanitize_bc(input logic [2:0] code);
        return (code > BC_MAX) ? BC_9600 : code;
    endfunction

    function automatic logic [2:0] next_bc(input logic [2:0] code);
        return (code >= BC_MAX) ? BC_9600 : code + 3'd1;
    endfunction

endpackage

// File: rtl/uart_rx_byte_fifo.sv
// Synchronous byte FIFO with flush; a push into a full FIFO is dropped and flagged
// by a registered one-cycle overflow pulse, unless a pop frees a slot in the same cycle.
module uart_rx_byte_fifo
    import uart_rx_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             overflow_q;
    logic             full, empty, do_push, do_pop, drop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_pop  = pop_i && !empty && !flush_i;
    assign do_push = push_i && (!full || do_pop) && !flush_i;
    assign drop    = push_i && full && !do_pop && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (flush_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= drop;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW + 1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (AW + 1)'(1);
            end
        end
    end

    // Storage carries no reset; occupancy is tracked entirely by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o     = mem_q[rd_ptr_q];
    assign empty_o    = empty;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_rx_link_manager.sv
// UART receive link supervisor: baud hunting, receiver reset sequencing and output byte buffering.
// Define UART_RX_LINK_STATS_EN to build the saturating parity-error and drop counters.
module uart_rx_link_manager
    import uart_rx_pkg::*;
#(
    parameter logic [2:0] START_BC   = 3'b000,
    parameter int         ERR_LIMIT  = 4,
    parameter int         GOOD_LOCK  = 4,
    parameter int         RST_CYC    = 16,
    parameter int         SETTLE_CYC = 64,
    parameter int         FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_par_err_i,
    input  logic        cfg_force_i,
    input  logic [2:0]  cfg_bc_i,
    output logic [2:0]  bc_o,
    output logic        link_rst_o,
    output logic        locked_o,
    output logic [7:0]  out_data_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        overflow_o,
    output logic [15:0] err_cnt_o,
    output logic [15:0] drop_cnt_o
);

    localparam int TMR_MAX = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYC - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [3:0]       ERR_LIM     = 4'(ERR_LIMIT);
    localparam logic [3:0]       GOOD_LIM    = 4'(GOOD_LOCK);

    link_state_e      state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [3:0]       good_run_q, good_run_d;
    logic [3:0]       err_run_q, err_run_d;
    logic [2:0]       bc_q, bc_d;
    logic             force_q;
    logic [2:0]       cfg_bc_q;
    logic [3:0]       err_next, good_next;
    logic             force_trig;
    logic             push, flush;
    logic             fifo_empty;
    logic             overflow;

    // A rising force, or any new forced code, must retune the receiver.
    assign force_trig = cfg_force_i && (!force_q || (cfg_bc_i != cfg_bc_q));
    assign err_next   = (err_run_q == ERR_LIM) ? err_run_q : err_run_q + 4'd1;
    assign good_next  = good_run_q + 4'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_RESET;
            tmr_q      <= '0;
            good_run_q <= '0;
            err_run_q  <= '0;
            bc_q       <= START_BC;
            force_q    <= 1'b0;
            cfg_bc_q   <= 3'b000;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            good_run_q <= good_run_d;
            err_run_q  <= err_run_d;
            bc_q       <= bc_d;
            force_q    <= cfg_force_i;
            cfg_bc_q   <= cfg_bc_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        good_run_d = good_run_q;
        err_run_d  = err_run_q;
        bc_d       = bc_q;
        push       = 1'b0;
        flush      = 1'b0;

        unique case (state_q)
            ST_RESET: begin
                if (tmr_q == RST_LAST) begin
                    state_d = ST_SETTLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_SETTLE: begin
                if (tmr_q == SETTLE_LAST) begin
                    state_d    = ST_HUNT;
                    tmr_d      = '0;
                    good_run_d = '0;
                    err_run_d  = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_HUNT: begin
                if (rx_valid_i && rx_par_err_i) begin
                    err_run_d  = err_next;
                    good_run_d = '0;
                    if (err_next == ERR_LIM && !cfg_force_i) begin
                        state_d = ST_STEP;
                    end
                end else if (rx_valid_i) begin
                    good_run_d = good_next;
                    if (good_next == GOOD_LIM) begin
                        state_d    = ST_LOCKED;
                        good_run_d = '0;
                        err_run_d  = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (rx_valid_i && rx_par_err_i) begin
                    err_run_d = err_next;
                    if (err_next == ERR_LIM && !cfg_force_i) begin
                        state_d = ST_STEP;
                    end
                end else if (rx_valid_i) begin
                    push      = 1'b1;
                    err_run_d = '0;
                end
            end
            ST_STEP: begin
                bc_d       = cfg_force_i ? sanitize_bc(cfg_bc_i) : next_bc(bc_q);
                flush      = 1'b1;
                state_d    = ST_RESET;
                tmr_d      = '0;
                good_run_d = '0;
                err_run_d  = '0;
            end
            default: begin
                state_d = ST_RESET;
                tmr_d   = '0;
            end
        endcase

        // A pending retune wins over any byte arriving in the same cycle.
        if (force_trig && state_q != ST_STEP) begin
            state_d = ST_STEP;
            push    = 1'b0;
        end
    end

    uart_rx_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (push),
        .data_i     (rx_data_i),
        .pop_i      (out_ready_i),
        .flush_i    (flush),
        .data_o     (out_data_o),
        .empty_o    (fifo_empty),
        .overflow_o (overflow)
    );

    assign bc_o        = bc_q;
    assign link_rst_o  = (state_q == ST_RESET);
    assign locked_o    = (state_q == ST_LOCKED);
    assign out_valid_o = !fifo_empty;
    assign overflow_o  = overflow;

`ifdef UART_RX_LINK_STATS_EN
    logic [15:0] err_cnt_q, drop_cnt_q;
    logic        err_evt;

    // Only bytes the link actually inspects contribute to the error total.
    assign err_evt = rx_valid_i && rx_par_err_i && (state_q == ST_HUNT || state_q == ST_LOCKED);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (err_evt && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
            if (overflow && drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign err_cnt_o  = err_cnt_q;
    assign drop_cnt_o = drop_cnt_q;
`else
    assign err_cnt_o  = 16'h0000;
    assign drop_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_rx_link_manager.sv
// Randomised and directed checks of uart_rx_link_manager against a time-window reference model.
// Works with or without UART_RX_LINK_STATS_EN defined.
module tb_uart_rx_link_manager;

    localparam logic [2:0] START_BC = 3'b000;
    localparam int ERR_LIMIT  = 4;
    localparam int GOOD_LOCK  = 4;
    localparam int RST_CYC    = 16;
    localparam int SETTLE_CYC = 64;
    localparam int FIFO_DEPTH = 8;
    localparam int ACTIVE_AT  = RST_CYC + SETTLE_CYC;

    logic        clk = 1'b0;
    logic        rstN;
    logic        rxValid;
    logic [7:0]  rxData;
    logic        rxParErr;
    logic        cfgForce;
    logic [2:0]  cfgBc;
    logic [2:0]  bc;
    logic        linkRst, locked;
    logic [7:0]  outData;
    logic        outValid, outReady, overflow;
    logic [15:0] errCnt, dropCnt;

    uart_rx_link_manager #(
        .START_BC   (START_BC),
        .ERR_LIMIT  (ERR_LIMIT),
        .GOOD_LOCK  (GOOD_LOCK),
        .RST_CYC    (RST_CYC),
        .SETTLE_CYC (SETTLE_CYC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .rx_valid_i   (rxValid),
        .rx_data_i    (rxData),
        .rx_par_err_i (rxParErr),
        .cfg_force_i  (cfgForce),
        .cfg_bc_i     (cfgBc),
        .bc_o         (bc),
        .link_rst_o   (linkRst),
        .locked_o     (locked),
        .out_data_o   (outData),
        .out_valid_o  (outValid),
        .out_ready_i  (outReady),
        .overflow_o   (overflow),
        .err_cnt_o    (errCnt),
        .drop_cnt_o   (dropCnt)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int ovfSeen    = 0;

    // Reference model: mSince counts cycles since the last rate change; the
    // link is resetting, settling or listening purely by which window it falls in.
    int   mBc, mSince, mGood, mErr, mErrCnt, mDropCnt, cPrev;
    bit   mLocked, mStep, fPrev, mOvfNow;
    logic [7:0] mQ[$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mBc = START_BC; mSince = 0; mGood = 0; mErr = 0;
        mErrCnt = 0; mDropCnt = 0; cPrev = 0;
        mLocked = 0; mStep = 0; fPrev = 0; mOvfNow = 0;
        mQ.delete();
    endtask

    task automatic modelEdge();
        bit trig, stepNext, doPush, doPop;
        trig     = cfgForce && (!fPrev || int'(cfgBc) != cPrev);
        stepNext = 0;
        doPush   = 0;
        if (mOvfNow && mDropCnt < 65535) mDropCnt++;
        mOvfNow = 0;
        if (mStep) begin
            if (cfgForce) mBc = (cfgBc > 3'd4) ? 0 : int'(cfgBc);
            else          mBc = (mBc == 4) ? 0 : mBc + 1;
            mQ.delete();
            mSince = 0; mLocked = 0; mGood = 0; mErr = 0;
        end else begin
            doPop = outReady && (mQ.size() > 0);
            if (mSince >= ACTIVE_AT && rxValid) begin
                if (rxParErr) begin
                    if (mErrCnt < 65535) mErrCnt++;
                    if (mErr < ERR_LIMIT) mErr++;
                    if (!mLocked) mGood = 0;
                    if (mErr == ERR_LIMIT && !cfgForce) stepNext = 1;
                end else if (mLocked) begin
                    doPush = 1;
                    mErr   = 0;
                end else begin
                    mGood++;
                    if (mGood == GOOD_LOCK) begin
                        mLocked = 1; mGood = 0; mErr = 0;
                    end
                end
            end
            if (trig) begin
                stepNext = 1;
                doPush   = 0;
            end
            if (doPop) void'(mQ.pop_front());
            if (doPush) begin
                if (mQ.size() < FIFO_DEPTH) mQ.push_back(rxData);
                else mOvfNow = 1;
            end
            if (mSince < 100000) mSince++;
        end
        mStep = stepNext;
        fPrev = cfgForce;
        cPrev = int'(cfgBc);
    endtask

    task automatic checkAll();
        checkOutput("bc", 32'(bc), 32'(mBc));
        checkOutput("link_rst", 32'(linkRst), 32'(!mStep && mSince < RST_CYC));
        checkOutput("locked", 32'(locked), 32'(mLocked && !mStep));
        checkOutput("out_valid", 32'(outValid), 32'(mQ.size() > 0));
        if (mQ.size() > 0) checkOutput("out_data", 32'(outData), 32'(mQ[0]));
        checkOutput("overflow", 32'(overflow), 32'(mOvfNow));
`ifdef UART_RX_LINK_STATS_EN
        checkOutput("err_cnt", 32'(errCnt), 32'(mErrCnt));
        checkOutput("drop_cnt", 32'(dropCnt), 32'(mDropCnt));
`else
        checkOutput("err_cnt", 32'(errCnt), 32'd0);
        checkOutput("drop_cnt", 32'(dropCnt), 32'd0);
`endif
    endtask

    task automatic runCycle();
        @(posedge clk);
        if (!rstN) modelReset();
        else       modelEdge();
        #1;
        checkAll();
        if (overflow) ovfSeen++;
    endtask

    task automatic applyStimulus(input bit v, input bit pe, input logic [7:0] d);
        rxValid  = v;
        rxParErr = pe;
        rxData   = d;
        runCycle();
        rxValid  = 1'b0;
        rxParErr = 1'b0;
    endtask

    task automatic waitActive();
        int guard = 0;
        while ((mStep || mSince < ACTIVE_AT) && guard < 400) begin
            applyStimulus(0, 0, 8'h00);
            guard++;
        end
        if (guard >= 400) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL wait_active: no listening window after %0d cycles", guard);
        end
    endtask

    task automatic lockUp();
        waitActive();
        repeat (GOOD_LOCK) applyStimulus(1, 0, 8'($urandom));
        checkOutput("lock_reached", 32'(locked), 32'd1);
    endtask

    task automatic errorBurst(input int n);
        repeat (n) applyStimulus(1, 1, 8'($urandom));
    endtask

    initial begin
        rstN = 1'b0; rxValid = 1'b0; rxData = 8'h00; rxParErr = 1'b0;
        cfgForce = 1'b0; cfgBc = 3'b000; outReady = 1'b0;
        modelReset();
        #12;
        checkAll();
        runCycle();
        rstN = 1'b1;

        // 1: reset window, ignored settle window, then lock at the start rate
        repeat (ACTIVE_AT) applyStimulus($urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom));
        repeat (GOOD_LOCK) applyStimulus(1, 0, 8'($urandom));
        checkOutput("t1_locked", 32'(locked), 32'd1);
        checkOutput("t1_bc", 32'(bc), 32'(START_BC));

        // 2: walk up to 57600, queue bytes, step to 115200, then wrap to 9600
        repeat (3) begin
            errorBurst(ERR_LIMIT);
            lockUp();
        end
        checkOutput("t2_bc_57600", 32'(bc), 32'd3);
        repeat (3) applyStimulus(1, 0, 8'($urandom));
        errorBurst(ERR_LIMIT);
        applyStimulus(0, 0, 8'h00);
        checkOutput("t2_bc_115200", 32'(bc), 32'd4);
        checkOutput("t2_flushed", 32'(outValid), 32'd0);
        checkOutput("t2_link_rst", 32'(linkRst), 32'd1);
        lockUp();
        errorBurst(ERR_LIMIT);
        applyStimulus(0, 0, 8'h00);
        checkOutput("t2_bc_wrap", 32'(bc), 32'd0);

        // 3: ten bytes into an eight-deep FIFO with no consumer
        lockUp();
        ovfSeen = 0;
        repeat (10) applyStimulus(1, 0, 8'($urandom));
        applyStimulus(0, 0, 8'h00);
        checkOutput("t3_overflows", 32'(ovfSeen), 32'd2);

        // 4: full FIFO, simultaneous pop and push
        outReady = 1'b1;
        applyStimulus(1, 0, 8'hA5);
        checkOutput("t4_no_overflow", 32'(overflow), 32'd0);
        outReady = 1'b0;
        applyStimulus(0, 0, 8'h00);
        outReady = 1'b1;
        repeat (FIFO_DEPTH + 2) applyStimulus(0, 0, 8'h00);

        // 5: forced rate, errors ignored, out-of-range code
        cfgBc = 3'b010; cfgForce = 1'b1;
        applyStimulus(0, 0, 8'h00);
        applyStimulus(0, 0, 8'h00);
        checkOutput("t5_forced_bc", 32'(bc), 32'd2);
        waitActive();
        errorBurst(20);
        checkOutput("t5_bc_held", 32'(bc), 32'd2);
        checkOutput("t5_no_reset", 32'(linkRst), 32'd0);
        cfgBc = 3'b111;
        applyStimulus(0, 0, 8'h00);
        applyStimulus(0, 0, 8'h00);
        checkOutput("t5_bad_code", 32'(bc), 32'd0);
        cfgForce = 1'b0;

        // random traffic with occasional force changes
        for (int i = 0; i < 2500; i++) begin
            outReady = 1'($urandom_range(0, 1));
            if ($urandom % 300 == 0) cfgForce = ~cfgForce;
            if (cfgForce && $urandom % 100 == 0) cfgBc = 3'($urandom);
            applyStimulus($urandom % 3 == 0, $urandom % 6 == 0, 8'($urandom));
        end

        // 6: asynchronous reset while locked with five bytes queued
        cfgForce = 1'b0; outReady = 1'b0;
        #2 rstN = 1'b0;
        #1 modelReset();
        checkAll();
        runCycle();
        rstN = 1'b1;
        lockUp();
        repeat (5) applyStimulus(1, 0, 8'($urandom));
        checkOutput("t6_queued", 32'(outValid), 32'd1);
        #3 rstN = 1'b0;
        #1;
        checkOutput("t6_out_valid", 32'(outValid), 32'd0);
        checkOutput("t6_locked", 32'(locked), 32'd0);
        checkOutput("t6_bc", 32'(bc), 32'(START_BC));
        checkOutput("t6_link_rst", 32'(linkRst), 32'd1);
        modelReset();
        runCycle();
        rstN = 1'b1;
        repeat (20) applyStimulus(0, 0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
